// File: rtl/ay_array.sv
// ay_array: multi-chip AY/YM bus front end with chip select, strobe
// generation, shared clock enable, read-back mux and a time-multiplexed
// stereo mixer summing every chip channel into left/right samples.
module ay_array #(
  parameter int N_CHIPS = 3,
  parameter int CE_DIV  = 4,
  parameter int MIX_DIV = 512,
  parameter int OUT_W   = 8 + $clog2(N_CHIPS) + 2,
  localparam int SEL_W  = (N_CHIPS > 1) ? $clog2(N_CHIPS) : 1
) (
  input  logic                   clk28,
  input  logic                   rst,
  input  logic                   ck35,
  input  logic                   en,
  input  logic                   ioreq,
  input  logic                   rd,
  input  logic                   wr,
  input  logic [15:0]            a_reg,
  input  logic [7:0]             d_reg,
  input  logic [1:0]             stereo_mode,
  input  logic [N_CHIPS-1:0]     mute_mask,
  input  logic [8*N_CHIPS-1:0]   ay_dout,
  input  logic [24*N_CHIPS-1:0]  ay_ch,
  output logic                   ay_ce,
  output logic [N_CHIPS-1:0]     ay_bc1,
  output logic [N_CHIPS-1:0]     ay_bdir,
  output logic [N_CHIPS-1:0]     ay_reset,
  output logic [7:0]             d_out,
  output logic                   d_out_active,
  output logic [SEL_W-1:0]       sel,
  output logic [OUT_W-1:0]       mix_l,
  output logic [OUT_W-1:0]       mix_r,
  output logic                   mix_valid
);

  localparam int CE_W  = $clog2(CE_DIV);
  localparam int PW    = $clog2(MIX_DIV);
  localparam int ACC_W = OUT_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} mix_state_t;

  // Flattened views of the per-chip buses
  logic [7:0] dout_arr [N_CHIPS];
  logic [7:0] ch_arr   [N_CHIPS][3];

  genvar gi, gj;
  generate
    for (gi = 0; gi < N_CHIPS; gi++) begin : g_chip
      assign dout_arr[gi] = ay_dout[8*gi +: 8];
      for (gj = 0; gj < 3; gj++) begin : g_ch
        assign ch_arr[gi][gj] = ay_ch[24*gi + 8*gj +: 8];
      end
    end
  endgenerate

  // Only a[15], a[14] and a[1] take part in the decode
  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_reg[13:2], a_reg[0]};

  logic fffd, bffd;
  assign fffd = ioreq & a_reg[15] & a_reg[14] & ~a_reg[1];
  assign bffd = ioreq & a_reg[15] & ~a_reg[1];

  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_CHIPS-1:0] bc1_q, bc1_d, bdir_q, bdir_d, reset_q;
  logic [CE_W-1:0]    ce_cnt_q, ce_cnt_d;
  logic               ce_q, ce_d;
  logic [PW-1:0]      per_cnt_q, per_cnt_d;
  logic               per_wrap;
  logic [2:0]         idx;

  // Bus strobes, chip select, clock-enable divider and mixer period counter
  always_comb begin
    bc1_d  = '0;
    bdir_d = '0;
    bc1_d[sel_q]  = en & fffd;
    bdir_d[sel_q] = en & bffd & wr;

    // Select writes use the complemented low bits: FF -> chip 0, FE -> chip 1
    idx   = ~d_reg[2:0];
    sel_d = sel_q;
    if (en && fffd && wr && (d_reg[7:3] == 5'b11111) && ({29'd0, idx} < 32'(N_CHIPS)))
      sel_d = idx[SEL_W-1:0];

    ce_cnt_d = ce_cnt_q;
    ce_d     = 1'b0;
    if (ck35) begin
      if (ce_cnt_q == CE_W'(CE_DIV - 1)) begin
        ce_cnt_d = '0;
        ce_d     = 1'b1;
      end else begin
        ce_cnt_d = ce_cnt_q + CE_W'(1);
      end
    end

    per_wrap  = (per_cnt_q == PW'(MIX_DIV - 1));
    per_cnt_d = per_wrap ? '0 : per_cnt_q + PW'(1);
  end

  // Register bus-side state; chip resets follow rst by one cycle
  always_ff @(posedge clk28) begin
    if (rst) begin
      sel_q     <= '0;
      bc1_q     <= '0;
      bdir_q    <= '0;
      reset_q   <= '1;
      ce_cnt_q  <= '0;
      ce_q      <= 1'b0;
      per_cnt_q <= '0;
    end else begin
      sel_q     <= sel_d;
      bc1_q     <= bc1_d;
      bdir_q    <= bdir_d;
      reset_q   <= '0;
      ce_cnt_q  <= ce_cnt_d;
      ce_q      <= ce_d;
      per_cnt_q <= per_cnt_d;
    end
  end

  assign sel          = sel_q;
  assign ay_bc1       = bc1_q;
  assign ay_bdir      = bdir_q;
  assign ay_reset     = reset_q;
  assign ay_ce        = ce_q;
  assign d_out_active = rd & (|bc1_q) & ~(|bdir_q);
  assign d_out        = d_out_active ? dout_arr[sel_q] : 8'hFF;

  // Mixer state
  mix_state_t         state_q;
  logic [SEL_W-1:0]   chip_q;
  logic [1:0]         ch_q;
  logic [1:0]         mode_lat_q;
  logic [N_CHIPS-1:0] mute_lat_q;
  logic [ACC_W-1:0]   acc_l_q, acc_r_q;
  logic [OUT_W-1:0]   mix_l_q, mix_r_q;
  logic               mix_valid_q;

  logic [7:0]         lvl;
  logic [ACC_W-1:0]   add_l, add_r, lvl_x, half_x;

  // Per-channel contribution to each side; ch_q 0=A, 1=B, 2=C
  always_comb begin
    lvl    = ch_arr[chip_q][ch_q];
    lvl_x  = ACC_W'(lvl);
    half_x = ACC_W'(lvl[7:1]);
    add_l  = '0;
    add_r  = '0;
    if (!mute_lat_q[chip_q]) begin
      case (mode_lat_q)
        2'd1: begin
          if (ch_q == 2'd0) add_l = lvl_x;
          else if (ch_q == 2'd1) begin add_l = half_x; add_r = half_x; end
          else add_r = lvl_x;
        end
        2'd2: begin
          if (ch_q == 2'd0) add_l = lvl_x;
          else if (ch_q == 2'd1) add_r = lvl_x;
          else begin add_l = half_x; add_r = half_x; end
        end
        default: begin
          add_l = lvl_x;
          add_r = lvl_x;
        end
      endcase
    end
  end

  // Mixer FSM: start on period wrap, walk every channel, publish saturated sums
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q     <= S_IDLE;
      chip_q      <= '0;
      ch_q        <= '0;
      mode_lat_q  <= '0;
      mute_lat_q  <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      mix_l_q     <= '0;
      mix_r_q     <= '0;
      mix_valid_q <= 1'b0;
    end else begin
      mix_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (per_wrap) begin
            state_q    <= S_ACC;
            chip_q     <= '0;
            ch_q       <= '0;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            mode_lat_q <= stereo_mode;
            mute_lat_q <= mute_mask;
          end
        end
        S_ACC: begin
          acc_l_q <= acc_l_q + add_l;
          acc_r_q <= acc_r_q + add_r;
          if (ch_q == 2'd2) begin
            ch_q <= '0;
            if (chip_q == SEL_W'(N_CHIPS - 1)) state_q <= S_DONE;
            else chip_q <= chip_q + SEL_W'(1);
          end else begin
            ch_q <= ch_q + 2'd1;
          end
        end
        S_DONE: begin
          mix_l_q     <= acc_l_q[OUT_W] ? {OUT_W{1'b1}} : acc_l_q[OUT_W-1:0];
          mix_r_q     <= acc_r_q[OUT_W] ? {OUT_W{1'b1}} : acc_r_q[OUT_W-1:0];
          mix_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mix_l     = mix_l_q;
  assign mix_r     = mix_r_q;
  assign mix_valid = mix_valid_q;

endmodule

// File: tb/tb_ay_array.sv
// tb_ay_array: directed bench for ay_array (3 chips) with a scoreboard of
// expected values pushed as stimulus is applied and popped on DUT output.
module tb_ay_array;

  localparam int N     = 3;
  localparam int OUT_W = 12;

  logic          clk28 = 1'b0;
  logic          rst, ck35, en, ioreq, rd, wr;
  logic [15:0]   a_reg;
  logic [7:0]    d_reg;
  logic [1:0]    stereo_mode;
  logic [N-1:0]  mute_mask;
  logic [8*N-1:0]  ay_dout;
  logic [24*N-1:0] ay_ch;
  logic          ay_ce;
  logic [N-1:0]  ay_bc1, ay_bdir, ay_reset;
  logic [7:0]    d_out;
  logic          d_out_active;
  logic [1:0]    sel;
  logic [OUT_W-1:0] mix_l, mix_r;
  logic          mix_valid;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  logic [31:0] sb_exp[$];
  string       sb_tag[$];

  ay_array #(.N_CHIPS(N), .CE_DIV(4), .MIX_DIV(512)) dut (
    .clk28(clk28), .rst(rst), .ck35(ck35), .en(en), .ioreq(ioreq), .rd(rd), .wr(wr),
    .a_reg(a_reg), .d_reg(d_reg), .stereo_mode(stereo_mode), .mute_mask(mute_mask),
    .ay_dout(ay_dout), .ay_ch(ay_ch), .ay_ce(ay_ce), .ay_bc1(ay_bc1), .ay_bdir(ay_bdir),
    .ay_reset(ay_reset), .d_out(d_out), .d_out_active(d_out_active), .sel(sel),
    .mix_l(mix_l), .mix_r(mix_r), .mix_valid(mix_valid)
  );

  always #5 clk28 = ~clk28;

  // Edge counter since reset release; mirrors where the mixer period sits
  always @(posedge clk28) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ck35: one-cycle strobe every 8 clk28 cycles
  initial begin
    ck35 = 1'b0;
    forever begin
      repeat (7) @(posedge clk28);
      #1 ck35 = 1'b1;
      @(posedge clk28);
      #1 ck35 = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    $display("check %s obs=%0h exp=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(string tag, logic [31:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic pop_check(logic [31:0] obs);
    string t;
    logic [31:0] e;
    if (sb_exp.size() == 0) begin
      n_checks++;
      n_err++;
      $error("FAIL scoreboard_empty: observed=%0h expected=none", obs);
    end else begin
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      check(t, obs, e);
    end
  endtask

  task automatic bus_idle();
    ioreq = 1'b0; rd = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_write(logic [15:0] addr, logic [7:0] data);
    ioreq = 1'b1; wr = 1'b1; rd = 1'b0; a_reg = addr; d_reg = data;
    tick();
    bus_idle();
  endtask

  task automatic wait_mix();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      tick();
      if (mix_valid) begin
        seen = 1'b1;
        break;
      end
    end
    check("mix_valid_seen", 32'(seen), 32'd1);
  endtask

  task automatic tick_until(int target);
    for (int i = 0; i < 2000 && cyc < target; i++) tick();
  endtask

  initial begin
    int rst_valid_hits;
    int t0;
    bit got;

    rst = 1'b1; en = 1'b1; bus_idle();
    a_reg = '0; d_reg = '0;
    ay_dout = {8'hA3, 8'h5A, 8'h11};
    ay_ch = {9{8'h80}};
    stereo_mode = 2'd1;
    mute_mask = '0;

    // Reset state
    rst_valid_hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (mix_valid) rst_valid_hits++;
    end
    push("rst_ay_reset", 32'h7);     pop_check(32'(ay_reset));
    push("rst_sel", 32'h0);          pop_check(32'(sel));
    push("rst_d_out", 32'hFF);       pop_check(32'(d_out));
    push("rst_d_out_active", 32'h0); pop_check(32'(d_out_active));
    push("rst_bc1_bdir", 32'h0);     pop_check(32'({ay_bc1, ay_bdir}));
    push("rst_ce_mix", 32'h0);       pop_check(32'({ay_ce, mix_l, mix_r}));
    push("rst_no_mix_valid", 32'h0); pop_check(32'(rst_valid_hits));
    rst = 1'b0;
    tick();
    push("ay_reset_released", 32'h0); pop_check(32'(ay_reset));

    // Select chip 1 with FE; the strobe itself lands on the previous chip 0
    push("sel_after_FE", 32'h1);
    push("bc1_on_select", 32'h1);
    bus_write(16'hFFFD, 8'hFE);
    pop_check(32'(sel));
    pop_check(32'(ay_bc1));
    tick();
    push("bc1_idle", 32'h0); pop_check(32'(ay_bc1));

    // Out-of-range chip index leaves sel alone
    push("sel_after_F8", 32'h1);
    bus_write(16'hFFFD, 8'hF8);
    pop_check(32'(sel));
    tick();

    // Register-select write goes to chip 1
    push("bc1_reg_select", 32'h2);
    bus_write(16'hFFFD, 8'h07);
    pop_check(32'(ay_bc1));
    tick();

    // Select chip 2, then data write via BFFD
    push("sel_after_FD", 32'h2);
    bus_write(16'hFFFD, 8'hFD);
    pop_check(32'(sel));
    tick();
    push("bdir_bffd", 32'h4);
    push("bc1_bffd", 32'h0);
    bus_write(16'hBFFD, 8'h55);
    pop_check(32'(ay_bdir));
    pop_check(32'(ay_bc1));
    tick();
    push("bdir_after", 32'h0); pop_check(32'(ay_bdir));

    // Read chip 2 through FFFD
    push("read_d_out", 32'hA3);
    push("read_active", 32'h1);
    ioreq = 1'b1; rd = 1'b1; wr = 1'b0; a_reg = 16'hFFFD;
    tick();
    pop_check(32'(d_out));
    pop_check(32'(d_out_active));
    bus_idle();
    tick();
    push("idle_d_out", 32'hFF); pop_check(32'(d_out));

    // Disabled port access
    en = 1'b0;
    push("en0_sel", 32'h2);
    push("en0_strobes", 32'h0);
    bus_write(16'hFFFD, 8'hFE);
    pop_check(32'(sel));
    pop_check(32'({ay_bc1, ay_bdir}));
    en = 1'b1;

    // Clock enable: width 1, period 32
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin tick(); if (ay_ce) got = 1'b1; end
    push("ce_first_seen", 32'h1); pop_check(32'(got));
    t0 = cyc;
    tick();
    push("ce_width", 32'h0); pop_check(32'(ay_ce));
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin tick(); if (ay_ce) got = 1'b1; end
    push("ce_period", 32'd32); pop_check(32'(cyc - t0));

    // Mixer: ABC, all 0x80, first wrap at edge 512 -> strobe at 522
    push("mix1_cyc", 32'd522); push("mix1_l", 32'h240); push("mix1_r", 32'h240);
    wait_mix();
    pop_check(32'(cyc)); pop_check(32'(mix_l)); pop_check(32'(mix_r));
    mute_mask = 3'b011;
    push("hold_valid", 32'h0); push("hold_l", 32'h240);
    tick();
    pop_check(32'(mix_valid)); pop_check(32'(mix_l));

    // Chips 0 and 1 muted
    push("mix2_cyc", 32'd1034); push("mix2_l", 32'hC0); push("mix2_r", 32'hC0);
    wait_mix();
    pop_check(32'(cyc)); pop_check(32'(mix_l)); pop_check(32'(mix_r));

    // Mono, all 0xFF
    stereo_mode = 2'd0; mute_mask = '0; ay_ch = {9{8'hFF}};
    push("mix3_cyc", 32'd1546); push("mix3_l", 32'h8F7); push("mix3_r", 32'h8F7);
    wait_mix();
    pop_check(32'(cyc)); pop_check(32'(mix_l)); pop_check(32'(mix_r));

    // ACB with A=10, B=20, C=40 on every chip
    stereo_mode = 2'd2; ay_ch = {3{24'h402010}};
    push("mix4_cyc", 32'd2058); push("mix4_l", 32'h90); push("mix4_r", 32'hC0);
    wait_mix();
    pop_check(32'(cyc)); pop_check(32'(mix_l)); pop_check(32'(mix_r));

    // Mode/mute changes mid-accumulation do not affect the running mix
    push("mix5_cyc", 32'd2570); push("mix5_l", 32'h90); push("mix5_r", 32'hC0);
    tick_until(2563);
    stereo_mode = 2'd1; mute_mask = 3'b111;
    wait_mix();
    pop_check(32'(cyc)); pop_check(32'(mix_l)); pop_check(32'(mix_r));

    // Reset mid-accumulation: outputs cleared, no strobe
    tick_until(3075);
    rst = 1'b1;
    push("midrst_mix", 32'h0); push("midrst_valid", 32'h0);
    tick();
    pop_check(32'({mix_l, mix_r})); pop_check(32'(mix_valid));
    rst = 1'b0;
    rst_valid_hits = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (mix_valid) rst_valid_hits++; end
    push("midrst_no_strobe", 32'h0); pop_check(32'(rst_valid_hits));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
